obi_mem_arbiter: RTL and testbench
==================================

# obi_mem_arbiter

Two-to-one arbiter that shares the single core-side memory port of the core-to-AXI bridge between the instruction-fetch and load/store requesters. It uses the req/gnt/rvalid memory protocol on all three sides and keeps an in-order ID FIFO of granted transactions so that each response returns to the requester that issued it. It sits between the core's two memory interfaces and the bridge's `data_*` port.

## Interface
- `ADDR_WIDTH`, 32, address width on all ports
- `DATA_WIDTH`, 32, data width; byte enables are `DATA_WIDTH/8`
- `MAX_OUTSTANDING`, 2, depth of the ID FIFO (>=1); maximum number of granted transactions without a response

- `clk_i` in 1: clock; one clock domain; all state on the rising edge
- `rst_ni` in 1: reset; asynchronous, active-low
- `m0_req_i`, `m0_addr_i`, `m0_we_i`, `m0_be_i`, `m0_wdata_i` in 1/ADDR/1/DATA/8/DATA: requester 0 (instruction fetch) request
- `m0_gnt_o`, `m0_rvalid_o` out 1: requester 0 grant and response valid
- `m0_rdata_o` out DATA: requester 0 read data
- `m1_*`: same set for requester 1 (load/store)
- `mem_req_o`, `mem_addr_o`, `mem_we_o`, `mem_be_o`, `mem_wdata_o` out: shared downstream request
- `mem_gnt_i`, `mem_rvalid_i` in 1; `mem_rdata_i` in DATA: shared downstream grant and response
- `err_o` out 1: one-cycle pulse on a protocol violation

## Operation
- Selection `sel` (0/1) picks the requester whose request fields drive `mem_*_o`.
- `mem_req_o = req[sel] & !fifo_full`.
- `mX_gnt_o = mem_gnt_i & mem_req_o & (sel==X)`.
- The unselected requester always sees gnt=0.
- Arbitration when unlocked:
  - Only one requester active: select it.
  - Both active: fixed priority to m1, or round-robin (see Configuration).
  - Neither active: `sel` holds its previous value.
- Lock: if `mem_req_o & !mem_gnt_i`, `sel` is frozen for the next cycle. Request fields must stay stable until gnt. The lock clears on the grant cycle.
- ID FIFO:
  - Handshake (`mem_req_o & mem_gnt_i`) pushes `sel`.
  - `mem_rvalid_i` pops the head and drives `m[head]_rvalid_o = 1`.
- `mem_rdata_i` is broadcast to both `mX_rdata_o`; it is only meaningful with the matching rvalid.
- Full FIFO: `mem_req_o` is forced to 0 and no grant is issued. There is no bypass, even when a pop occurs in the same cycle.
- Simultaneous push and pop when not full: both happen and the count is unchanged. Responses stay in order.
- `mem_rvalid_i` with an empty FIFO: the response is dropped, both rvalids stay 0, and `err_o` pulses.
- Arithmetic:
  - Read/write pointers are `$clog2(MAX_OUTSTANDING)` bits wide (minimum 1) and wrap modulo `MAX_OUTSTANDING`.
  - The count is `$clog2(MAX_OUTSTANDING+1)` bits wide.

## Timing
- Request, grant and response paths are purely combinational: zero added latency.
- Registered state: FIFO contents/pointers/count, lock flag, `sel`, last-granted pointer.
- Reset values:
  - FIFO empty, lock 0, `sel` 0, last-granted 1.
  - All outputs go low while reset is asserted: `mem_req_o` is 0 since the FIFO is empty and gated by reset.
  - `err_o` is 0.
- Reset mid-transaction flushes all in-flight IDs. Responses arriving after reset are treated as spurious and pulse `err_o`.
- `err_o` is registered: it asserts the cycle after the violation, for one cycle.

## Configuration
- `OBI_ARB_RR_EN` defined: round-robin arbitration.
  - On contention, grant the requester that was not last granted.
  - The last-granted pointer updates on every handshake.
- Not defined: fixed priority, m1 (load/store) always wins contention. The last-granted pointer is not implemented.

## Test plan
- Single read on m0, addr 0x100, gnt the same cycle, rvalid 2 cycles later with rdata 0xDEADBEEF -> `m0_gnt_o` in cycle 0, `m0_rvalid_o`=1 with 0xDEADBEEF, m1 sees nothing.
- m0 and m1 both request every cycle with gnt always 1:
  - Without the macro: m1 granted 4/4 cycles.
  - With `OBI_ARB_RR_EN`: grants alternate m0, m1, m0, m1 (first grant m0, since last-granted resets to 1).
- m0 requests and gnt is held low 3 cycles while m1 requests from cycle 1 -> `sel` stays 0, m0 is granted in cycle 3, m1 is granted afterwards.
- `MAX_OUTSTANDING`=2, two grants (m1, m0), no rvalid, third request pending:
  - `mem_req_o`=0 while full.
  - The first rvalid routes to m1, the second to m0.
  - `mem_req_o` reasserts the cycle after the first pop.
- `mem_rvalid_i` pulse with an empty FIFO -> no rvalid out, `err_o`=1 for exactly one cycle the next cycle.
- Assert `rst_ni`=0 with 2 outstanding, release, then pulse `mem_rvalid_i` -> no rvalid out, `err_o` pulses, count 0.

Source files
------------

// File: rtl/obi_mem_arbiter.sv
// Two-to-one req/gnt/rvalid arbiter with an in-order ID FIFO that routes each response back to its issuer.
// Define OBI_ARB_RR_EN for round-robin contention handling; otherwise m1 (load/store) has fixed priority.
module obi_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    m0_req_i,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_gnt_o,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,

    input  logic                    m1_req_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_gnt_o,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,

    output logic                    mem_req_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,

    output logic                    err_o
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

    // Handshake: a downstream transfer happens in a cycle with mem_req_o & mem_gnt_i;
    // once mem_req_o is raised the selected request must hold until that cycle.
    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    lock_state_e            state_q, state_d;
    logic                   sel_q, sel;
    logic                   contend_sel;
    logic [MAX_OUTSTANDING-1:0] id_q, id_d;
    logic [PTR_W-1:0]       wptr_q, wptr_d;
    logic [PTR_W-1:0]       rptr_q, rptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   fifo_full, fifo_empty;
    logic                   req_sel, push, pop, head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

`ifdef OBI_ARB_RR_EN
    logic last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else if (push) begin
            last_q <= sel;
        end
    end

    assign contend_sel = ~last_q;
`else
    assign contend_sel = 1'b1;
`endif

    assign fifo_full  = (cnt_q == CNT_MAX);
    assign fifo_empty = (cnt_q == '0);

    always_comb begin
        sel = sel_q;
        if (state_q == ST_OPEN) begin
            if (m0_req_i && m1_req_i) begin
                sel = contend_sel;
            end else if (m0_req_i) begin
                sel = 1'b0;
            end else if (m1_req_i) begin
                sel = 1'b1;
            end
        end
    end

    assign req_sel   = sel ? m1_req_i : m0_req_i;
    // Gated by reset so nothing leaves the block while rst_ni is low.
    assign mem_req_o = req_sel & ~fifo_full & rst_ni;
    assign push      = mem_req_o & mem_gnt_i;
    assign pop       = mem_rvalid_i & ~fifo_empty & rst_ni;
    assign head      = id_q[rptr_q];

    assign m0_gnt_o    = push & ~sel;
    assign m1_gnt_o    = push & sel;
    assign m0_rvalid_o = pop & ~head;
    assign m1_rvalid_o = pop & head;
    assign m0_rdata_o  = mem_rdata_i & {DATA_WIDTH{rst_ni}};
    assign m1_rdata_o  = mem_rdata_i & {DATA_WIDTH{rst_ni}};

    assign mem_addr_o  = (sel ? m1_addr_i  : m0_addr_i)  & {ADDR_WIDTH{rst_ni}};
    assign mem_we_o    = (sel ? m1_we_i    : m0_we_i)    & rst_ni;
    assign mem_be_o    = (sel ? m1_be_i    : m0_be_i)    & {(DATA_WIDTH/8){rst_ni}};
    assign mem_wdata_o = (sel ? m1_wdata_i : m0_wdata_i) & {DATA_WIDTH{rst_ni}};
    assign err_o       = err_q;

    always_comb begin
        state_d = (mem_req_o && !mem_gnt_i) ? ST_LOCKED : ST_OPEN;
        id_d    = id_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        err_d   = mem_rvalid_i & fifo_empty;
        if (push) begin
            id_d[wptr_q] = sel;
            wptr_d       = ptr_inc(wptr_q);
        end
        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_OPEN;
            sel_q   <= 1'b0;
            id_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel;
            id_q    <= id_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed bench for obi_mem_arbiter: grants checked per cycle, responses routed via an expected-ID queue.
// Expectations follow OBI_ARB_RR_EN when that macro is defined for the build.
module tb_obi_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        m0_req_i = 1'b0, m1_req_i = 1'b0;
    logic [31:0] m0_addr_i = '0, m1_addr_i = '0;
    logic        m0_we_i = 1'b0, m1_we_i = 1'b1;
    logic [3:0]  m0_be_i = 4'hF, m1_be_i = 4'h3;
    logic [31:0] m0_wdata_i = 32'h1111_0000, m1_wdata_i = 32'h2222_0000;
    logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        err_o;

    int n_assert = 0;
    int n_fail   = 0;
    logic [0:0] exp_q[$];
    logic       exp_id;

    obi_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
        .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
        .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .err_o(err_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver: one cycle of stimulus, applied at the falling edge and sampled 1 ns later
    task automatic cyc(input logic r0, input logic [31:0] a0, input logic r1, input logic [31:0] a1,
                       input logic g, input logic rv, input logic [31:0] rd);
        @(negedge clk_i);
        m0_req_i = r0; m0_addr_i = a0;
        m1_req_i = r1; m1_addr_i = a1;
        mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        m0_req_i = 1'b0; m1_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        exp_q.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // scoreboard: pop the oldest expected ID and check routing of the current response
    task automatic check_resp(input logic [31:0] data);
        logic id;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 64'(exp_q.size()), 64'd1);
        end else begin
            id = exp_q.pop_front();
            chk("rvalid_m0", 64'(m0_rvalid_o), 64'(!id));
            chk("rvalid_m1", 64'(m1_rvalid_o), 64'(id));
            chk("rdata", 64'(id ? m1_rdata_o : m0_rdata_o), 64'(data));
        end
    endtask

    initial begin
        // reset state, with a request present to show it is held off
        @(negedge clk_i);
        m0_req_i = 1'b1; m0_addr_i = 32'h40;
        #1;
        chk("rst_mem_req", 64'(mem_req_o), 64'd0);
        chk("rst_m0_gnt", 64'(m0_gnt_o), 64'd0);
        chk("rst_rvalid", 64'({m0_rvalid_o, m1_rvalid_o}), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        m0_req_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;

        // single read on m0
        cyc(1, 32'h100, 0, 0, 1, 0, 0);
        chk("t1_m0_gnt", 64'(m0_gnt_o), 64'd1);
        chk("t1_m1_gnt", 64'(m1_gnt_o), 64'd0);
        chk("t1_addr", 64'(mem_addr_o), 64'h100);
        exp_q.push_back(1'b0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("t1_idle_rvalid", 64'({m0_rvalid_o, m1_rvalid_o}), 64'd0);
        cyc(0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        check_resp(32'hDEADBEEF);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("t1_err", 64'(err_o), 64'd0);

        // contention, gnt always high, one response per cycle behind the grants
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1, 32'h200, 1, 32'h300, 1, i > 0, 32'hA000 + 32'(i));
            if (i > 0) check_resp(32'hA000 + 32'(i));
`ifdef OBI_ARB_RR_EN
            exp_id = (i % 2) == 1;
`else
            exp_id = 1'b1;
`endif
            chk($sformatf("t2_m0_gnt_%0d", i), 64'(m0_gnt_o), 64'(!exp_id));
            chk($sformatf("t2_m1_gnt_%0d", i), 64'(m1_gnt_o), 64'(exp_id));
            chk($sformatf("t2_addr_%0d", i), 64'(mem_addr_o), exp_id ? 64'h300 : 64'h200);
            chk($sformatf("t2_we_be_wd_%0d", i), {27'd0, mem_we_o, mem_be_o, mem_wdata_o},
                exp_id ? {27'd0, 1'b1, 4'h3, 32'h2222_0000} : {27'd0, 1'b0, 4'hF, 32'h1111_0000});
            exp_q.push_back(exp_id);
        end
        cyc(0, 0, 0, 0, 0, 1, 32'hA004);
        check_resp(32'hA004);

        // lock: m0 waits three cycles for gnt while m1 joins
        cyc(1, 32'h600, 0, 0, 0, 0, 0);
        chk("t3_addr_c0", 64'(mem_addr_o), 64'h600);
        chk("t3_gnt_c0", 64'({m0_gnt_o, m1_gnt_o}), 64'd0);
        for (int i = 1; i < 3; i++) begin
            cyc(1, 32'h600, 1, 32'h700, 0, 0, 0);
            chk($sformatf("t3_addr_c%0d", i), 64'(mem_addr_o), 64'h600);
            chk($sformatf("t3_m1_gnt_c%0d", i), 64'(m1_gnt_o), 64'd0);
        end
        cyc(1, 32'h600, 1, 32'h700, 1, 0, 0);
        chk("t3_m0_gnt_c3", 64'(m0_gnt_o), 64'd1);
        chk("t3_m1_gnt_c3", 64'(m1_gnt_o), 64'd0);
        exp_q.push_back(1'b0);
        cyc(0, 0, 1, 32'h700, 1, 0, 0);
        chk("t3_m1_gnt_c4", 64'(m1_gnt_o), 64'd1);
        chk("t3_addr_c4", 64'(mem_addr_o), 64'h700);
        exp_q.push_back(1'b1);
        cyc(0, 0, 0, 0, 0, 1, 32'hC0);
        check_resp(32'hC0);
        cyc(0, 0, 0, 0, 0, 1, 32'hC1);
        check_resp(32'hC1);

        // full FIFO: grants m1 then m0, third request held off until after a pop
        cyc(0, 0, 1, 32'h800, 1, 0, 0);
        chk("t4_m1_gnt", 64'(m1_gnt_o), 64'd1);
        chk("t4_we", 64'(mem_we_o), 64'd1);
        exp_q.push_back(1'b1);
        cyc(1, 32'h900, 0, 0, 1, 0, 0);
        chk("t4_m0_gnt", 64'(m0_gnt_o), 64'd1);
        exp_q.push_back(1'b0);
        cyc(1, 32'h904, 0, 0, 1, 0, 0);
        chk("t4_full_req", 64'(mem_req_o), 64'd0);
        chk("t4_full_gnt", 64'(m0_gnt_o), 64'd0);
        cyc(1, 32'h904, 0, 0, 1, 1, 32'hB0);
        check_resp(32'hB0);
        chk("t4_nobypass_req", 64'(mem_req_o), 64'd0);
        chk("t4_nobypass_gnt", 64'(m0_gnt_o), 64'd0);
        cyc(1, 32'h904, 0, 0, 1, 0, 0);
        chk("t4_reassert_req", 64'(mem_req_o), 64'd1);
        chk("t4_reassert_gnt", 64'(m0_gnt_o), 64'd1);
        exp_q.push_back(1'b0);
        cyc(0, 0, 0, 0, 0, 1, 32'hB1);
        check_resp(32'hB1);
        cyc(0, 0, 0, 0, 0, 1, 32'hB2);
        check_resp(32'hB2);

        // spurious response with an empty FIFO
        cyc(0, 0, 0, 0, 0, 1, 32'h5555);
        chk("t5_rvalid", 64'({m0_rvalid_o, m1_rvalid_o}), 64'd0);
        chk("t5_err_same", 64'(err_o), 64'd0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("t5_err_next", 64'(err_o), 64'd1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("t5_err_after", 64'(err_o), 64'd0);

        // reset with two outstanding flushes the IDs
        cyc(1, 32'hA00, 0, 0, 1, 0, 0);
        chk("t6_m0_gnt", 64'(m0_gnt_o), 64'd1);
        cyc(0, 0, 1, 32'hB00, 1, 0, 0);
        chk("t6_m1_gnt", 64'(m1_gnt_o), 64'd1);
        @(negedge clk_i);
        rst_ni = 1'b0; m1_req_i = 1'b0; m0_req_i = 1'b1;
        exp_q.delete();
        #1;
        chk("t6_rst_req", 64'(mem_req_o), 64'd0);
        chk("t6_rst_gnt", 64'(m0_gnt_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1; m0_req_i = 1'b0;
        cyc(0, 0, 0, 0, 0, 1, 32'h6666);
        chk("t6_rvalid", 64'({m0_rvalid_o, m1_rvalid_o}), 64'd0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("t6_err", 64'(err_o), 64'd1);
        // count back to 0: two grants fit, the third is held
        cyc(1, 32'hC00, 0, 0, 1, 0, 0);
        chk("t6_err_clear", 64'(err_o), 64'd0);
        chk("t6_cnt_g1", 64'(m0_gnt_o), 64'd1);
        exp_q.push_back(1'b0);
        cyc(1, 32'hC04, 0, 0, 1, 0, 0);
        chk("t6_cnt_g2", 64'(m0_gnt_o), 64'd1);
        exp_q.push_back(1'b0);
        cyc(1, 32'hC08, 0, 0, 1, 0, 0);
        chk("t6_cnt_full", 64'(mem_req_o), 64'd0);
        cyc(0, 0, 0, 0, 0, 1, 32'hD0);
        check_resp(32'hD0);
        cyc(0, 0, 0, 0, 0, 1, 32'hD1);
        check_resp(32'hD1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("t6_final_err", 64'(err_o), 64'd0);
        chk("sb_leftover", 64'(exp_q.size()), 64'd0);

        // report
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
